shift_unit: RTL and testbench

- Iterative multi-mode shifter/rotator for the Mini-SRC datapath ALU path.
- Generalises the single-mode SHR path to five modes, parametrised width and a configurable shift step per cycle.
- Shares the datapath OP encoding and uses a start/done handshake, so the control unit can stall on busy.
- Result feeds the Z register path (ZLowin) once done is asserted.

---
 rtl/shift_unit_if.sv | 35 +++
 rtl/shift_unit.sv | 163 ++++++++++++++++
 tb/tb_shift_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_unit_if.sv
// Start/done handshake and operand bus between the control unit and shift_unit.
// Carries carry_out only when SHIFT_CARRY_EN is defined.
interface shift_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [4:0]       OP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             op_err;
`ifdef SHIFT_CARRY_EN
  logic             carry_out;

  modport master (
    output start, OP, A, B,
    input  result, busy, done, op_err, carry_out
  );
  modport slave (
    input  start, OP, A, B,
    output result, busy, done, op_err, carry_out
  );
`else
  modport master (
    output start, OP, A, B,
    input  result, busy, done, op_err
  );
  modport slave (
    input  start, OP, A, B,
    output result, busy, done, op_err
  );
`endif
endinterface

// File: rtl/shift_unit.sv
// Iterative multi-mode shifter/rotator (SHR, SHRA, SHL, ROR, ROL), up to STEP bits per clock.
// Optional carry_out enabled by the SHIFT_CARRY_EN macro.
module shift_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input logic         Clock,
  input logic         Clear,
  shift_unit_if.slave bus
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] WidthC = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] StepC  = CNT_W'(STEP);
  localparam logic [WIDTH-1:0] WidthB = WIDTH'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [2:0] {ModeShr, ModeShra, ModeShl, ModeRor, ModeRol} mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_err_q, op_err_d;

  logic             legal;
  mode_e            acc_mode;
  logic [CNT_W-1:0] acc_n;
  logic [CNT_W-1:0] step_k;
  logic [WIDTH-1:0] shifted;

  // Decode the incoming OP and derive the effective count n.
  always_comb begin
    legal    = 1'b1;
    acc_mode = ModeShr;
    case (bus.OP)
      5'b01000: acc_mode = ModeShr;
      5'b01001: acc_mode = ModeShra;
      5'b01010: acc_mode = ModeShl;
      5'b01011: acc_mode = ModeRor;
      5'b01100: acc_mode = ModeRol;
      default:  legal    = 1'b0;
    endcase
    if (!legal) begin
      acc_n = '0;
    end else if (acc_mode == ModeRor || acc_mode == ModeRol) begin
      acc_n = {1'b0, bus.B[IdxW-1:0]};
    end else if (bus.B >= WidthB) begin
      acc_n = WidthC;
    end else begin
      acc_n = bus.B[CNT_W-1:0];
    end
  end

  assign step_k = (cnt_q > StepC) ? StepC : cnt_q;

  always_comb begin
    shifted = work_q;
    case (mode_q)
      ModeShr:  shifted = work_q >> step_k;
      ModeShra: shifted = $signed(work_q) >>> step_k;
      ModeShl:  shifted = work_q << step_k;
      ModeRor:  shifted = (work_q >> step_k) | (work_q << (WidthC - step_k));
      ModeRol:  shifted = (work_q << step_k) | (work_q >> (WidthC - step_k));
      default:  shifted = work_q;
    endcase
  end

`ifdef SHIFT_CARRY_EN
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] lo_tmp, hi_tmp;
  logic             out_bit;

  // Right-moving modes lose bit k-1 last; left-moving modes lose bit WIDTH-k last.
  always_comb begin
    lo_tmp = step_k - 1'b1;
    hi_tmp = WidthC - step_k;
    if (mode_q == ModeShl || mode_q == ModeRol) begin
      out_bit = work_q[hi_tmp[IdxW-1:0]];
    end else begin
      out_bit = work_q[lo_tmp[IdxW-1:0]];
    end
  end

  assign bus.carry_out = carry_q;
`endif

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    work_d   = work_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_err_d = op_err_q;
`ifdef SHIFT_CARRY_EN
    carry_d  = carry_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          work_d   = bus.A;
          mode_d   = acc_mode;
          cnt_d    = acc_n;
          op_err_d = !legal;
          if (acc_n == '0) begin
            result_d = bus.A;
`ifdef SHIFT_CARRY_EN
            carry_d  = 1'b0;
`endif
            state_d  = StDone;
          end else begin
            state_d  = StShift;
          end
        end
      end
      StShift: begin
        work_d = shifted;
        cnt_d  = cnt_q - step_k;
        if (cnt_q == step_k) begin
          result_d = shifted;
`ifdef SHIFT_CARRY_EN
          carry_d  = out_bit;
`endif
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q  <= StIdle;
      mode_q   <= ModeShr;
      work_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_err_q <= 1'b0;
`ifdef SHIFT_CARRY_EN
      carry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      work_q   <= work_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_err_q <= op_err_d;
`ifdef SHIFT_CARRY_EN
      carry_q  <= carry_d;
`endif
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = (state_q == StShift);
  assign bus.done   = (state_q == StDone);
  assign bus.op_err = op_err_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed-vector bench for shift_unit (WIDTH=32, STEP=4); carry checks active with SHIFT_CARRY_EN.
module tb_shift_unit;

  localparam logic [4:0] OpShr  = 5'b01000;
  localparam logic [4:0] OpShra = 5'b01001;
  localparam logic [4:0] OpShl  = 5'b01010;
  localparam logic [4:0] OpRor  = 5'b01011;
  localparam logic [4:0] OpRol  = 5'b01100;

  logic Clock = 1'b0;
  logic Clear = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  shift_unit_if #(.WIDTH(32)) bus ();

  shift_unit #(.WIDTH(32), .STEP(4)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Accept edge E0, then count edges until done shows; inputs are scrambled after E0.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                        output int lat, output int busy_cnt);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.OP    = op;
    tick();
    bus.start = 1'b0;
    bus.A     = 32'h5555_AAAA;
    bus.B     = 32'd7;
    bus.OP    = 5'b00000;
    lat       = 0;
    busy_cnt  = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    Clear = 1'b0;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.OP = '0;
    #12;
    n_vec++;
    if ({bus.busy, bus.done, bus.op_err} !== 3'b000) begin
      $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.op_err});
      n_err++;
    end
    n_vec++;
    if (bus.result !== 32'h0) begin
      $display("FAIL reset_result: got %h want 00000000", bus.result);
      n_err++;
    end
`ifdef SHIFT_CARRY_EN
    n_vec++;
    if (bus.carry_out !== 1'b0) begin
      $display("FAIL reset_carry: got %b want 0", bus.carry_out);
      n_err++;
    end
`endif
    @(negedge Clock);
    Clear = 1'b1;
    tick();
  endtask

  task automatic test_shr();
    int lat, bc;
    run_op(32'hFEDB_CA98, 32'h0A, OpShr, lat, bc);
    n_vec++;
    if (lat !== 3 || bc !== 3) begin
      $display("FAIL shr_latency: got lat=%0d busy=%0d want 3/3", lat, bc);
      n_err++;
    end
    n_vec++;
    if (bus.result !== 32'h003F_B6F2 || bus.op_err !== 1'b0) begin
      $display("FAIL shr_result: got %h err=%b want 003fb6f2 err=0", bus.result, bus.op_err);
      n_err++;
    end
`ifdef SHIFT_CARRY_EN
    n_vec++;
    if (bus.carry_out !== 1'b1) begin
      $display("FAIL shr_carry: got %b want 1", bus.carry_out);
      n_err++;
    end
`endif
    tick();
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'h003F_B6F2) begin
      $display("FAIL shr_idle_hold: got done=%b busy=%b res=%h want 0/0/003fb6f2",
               bus.done, bus.busy, bus.result);
      n_err++;
    end
  endtask

  task automatic test_shra_clamp();
    int lat, bc;
    run_op(32'h8000_0000, 32'd40, OpShra, lat, bc);
    n_vec++;
    if (lat !== 8 || bc !== 8) begin
      $display("FAIL shra_latency: got lat=%0d busy=%0d want 8/8", lat, bc);
      n_err++;
    end
    n_vec++;
    if (bus.result !== 32'hFFFF_FFFF) begin
      $display("FAIL shra_result: got %h want ffffffff", bus.result);
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run_op(32'h1234_5678, 32'd36, OpRol, lat, bc);
    n_vec++;
    if (lat !== 1 || bus.result !== 32'h2345_6781) begin
      $display("FAIL rol_result: got lat=%0d res=%h want 1/23456781", lat, bus.result);
      n_err++;
    end
`ifdef SHIFT_CARRY_EN
    n_vec++;
    if (bus.carry_out !== 1'b1) begin
      $display("FAIL rol_carry: got %b want 1", bus.carry_out);
      n_err++;
    end
`endif
    // Still in DONE here: this start must be taken on the very next edge.
    run_op(32'h0000_0001, 32'd1, OpRor, lat, bc);
    n_vec++;
    if (lat !== 1 || bc !== 1 || bus.result !== 32'h8000_0000) begin
      $display("FAIL ror_b2b: got lat=%0d busy=%0d res=%h want 1/1/80000000", lat, bc, bus.result);
      n_err++;
    end
`ifdef SHIFT_CARRY_EN
    n_vec++;
    if (bus.carry_out !== 1'b1) begin
      $display("FAIL ror_carry: got %b want 1", bus.carry_out);
      n_err++;
    end
`endif
  endtask

  task automatic test_zero_and_illegal();
    int lat, bc;
    run_op(32'h0000_000A, 32'd0, OpShl, lat, bc);
    n_vec++;
    if (lat !== 0 || bc !== 0 || bus.result !== 32'h0000_000A || bus.op_err !== 1'b0) begin
      $display("FAIL shl_zero: got lat=%0d busy=%0d res=%h err=%b want 0/0/0000000a/0",
               lat, bc, bus.result, bus.op_err);
      n_err++;
    end
`ifdef SHIFT_CARRY_EN
    n_vec++;
    if (bus.carry_out !== 1'b0) begin
      $display("FAIL zero_carry: got %b want 0", bus.carry_out);
      n_err++;
    end
`endif
    tick();
    run_op(32'h0000_BEEF, 32'd5, 5'b00011, lat, bc);
    n_vec++;
    if (lat !== 0 || bc !== 0 || bus.result !== 32'h0000_BEEF || bus.op_err !== 1'b1) begin
      $display("FAIL illegal_op: got lat=%0d busy=%0d res=%h err=%b want 0/0/0000beef/1",
               lat, bc, bus.result, bus.op_err);
      n_err++;
    end
    tick();
    run_op(32'h0000_0001, 32'd4, OpShl, lat, bc);
    n_vec++;
    if (lat !== 1 || bus.result !== 32'h0000_0010 || bus.op_err !== 1'b0) begin
      $display("FAIL err_clear: got lat=%0d res=%h err=%b want 1/00000010/0",
               lat, bus.result, bus.op_err);
      n_err++;
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int lat, bc;
    bus.start = 1'b1;
    bus.A     = 32'hFFFF_0000;
    bus.B     = 32'd20;
    bus.OP    = OpShr;
    tick();
    bus.start = 1'b0;
    tick();
    #2;
    Clear = 1'b0;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      $display("FAIL mid_reset: got busy=%b done=%b res=%h want 0/0/00000000",
               bus.busy, bus.done, bus.result);
      n_err++;
    end
    @(negedge Clock);
    Clear = 1'b1;
    tick();
    run_op(32'hFFFF_0000, 32'd20, OpShr, lat, bc);
    n_vec++;
    if (lat !== 5 || bc !== 5 || bus.result !== 32'h0000_0FFF) begin
      $display("FAIL post_reset_op: got lat=%0d busy=%0d res=%h want 5/5/00000fff",
               lat, bc, bus.result);
      n_err++;
    end
    tick();
  endtask

  task automatic test_ignored_start();
    bus.start = 1'b1;
    bus.A     = 32'h8000_0000;
    bus.B     = 32'd12;
    bus.OP    = OpShr;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.A     = 32'hFFFF_FFFF;
    bus.B     = 32'd1;
    bus.OP    = OpShl;
    tick();
    bus.start = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      $display("FAIL ignore_busy: got busy=%b done=%b want 1/0", bus.busy, bus.done);
      n_err++;
    end
    tick();
    n_vec++;
    if (bus.done !== 1'b1 || bus.result !== 32'h0008_0000) begin
      $display("FAIL ignore_result: got done=%b res=%h want 1/00080000", bus.done, bus.result);
      n_err++;
    end
`ifdef SHIFT_CARRY_EN
    n_vec++;
    if (bus.carry_out !== 1'b0) begin
      $display("FAIL ignore_carry: got %b want 0", bus.carry_out);
      n_err++;
    end
`endif
    tick();
    tick();
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'h0008_0000) begin
      $display("FAIL ignore_no_extra: got done=%b busy=%b res=%h want 0/0/00080000",
               bus.done, bus.busy, bus.result);
      n_err++;
    end
  endtask

  initial begin
    test_reset();
    test_shr();
    test_shra_clamp();
    test_back_to_back();
    test_zero_and_illegal();
    test_reset_mid_op();
    test_ignored_start();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
